// File: rtl/pwm_bank.sv
// pwm_bank: NUM_CH PWM/static outputs with prescaler, run bit and period-aligned duty commit; `PWM_POLARITY_EN adds per-channel polarity registers at 0x0C+k
module pwm_bank #(
  parameter int NUM_CH  = 16,
  parameter int DUTY_W  = 8,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);
  localparam int NB = NUM_CH / 8;
  localparam logic [DUTY_W-1:0] LAST = {{(DUTY_W-1){1'b1}}, 1'b0};

  logic [NUM_CH-1:0]  en_out_q, en_out_d, en_pwm_q, en_pwm_d, out_q, out_d, pol;
  logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic [DUTY_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0]  duty_pend_q [NUM_CH];
  logic [DUTY_W-1:0]  duty_pend_d [NUM_CH];
  logic [DUTY_W-1:0]  duty_act_q [NUM_CH];
  logic [DUTY_W-1:0]  duty_act_d [NUM_CH];
  logic               run_q, run_d, ps_q, tick, wrap;

  assign tick = run_q && (pcnt_q >= presc_q);
  assign wrap = tick && (cnt_q == LAST);
  assign out = out_q;
  assign period_start = ps_q;

  // Register write decode; anything outside the map falls through unchanged
  always_comb begin
    en_out_d = en_out_q;
    en_pwm_d = en_pwm_q;
    presc_d = (wr_en && wr_addr == 8'h08) ? wr_data[PRESC_W-1:0] : presc_q;
    run_d = (wr_en && wr_addr == 8'h09) ? wr_data[0] : run_q;
    for (int k = 0; k < NB; k++) begin
      if (wr_en && wr_addr == 8'(k)) en_out_d[8*k +: 8] = wr_data;
      if (wr_en && wr_addr == 8'(4 + k)) en_pwm_d[8*k +: 8] = wr_data;
    end
    for (int i = 0; i < NUM_CH; i++)
      duty_pend_d[i] = (wr_en && wr_addr == 8'(16 + i)) ? wr_data[DUTY_W-1:0] : duty_pend_q[i];
  end

  // Counters and duty commit; the commit uses the next pending value so a write on the wrap lands at once
  always_comb begin
    pcnt_d = (!run_q || tick) ? '0 : pcnt_q + 1'b1;
    cnt_d = (!run_q || wrap) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
    for (int i = 0; i < NUM_CH; i++)
      duty_act_d[i] = (!run_q || wrap) ? duty_pend_d[i] : duty_act_q[i];
  end

  // Output level per channel: disabled channels are always low, polarity applies only to enabled ones
  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      out_d[i] = en_out_q[i] & ((en_pwm_q[i] ? (cnt_q < duty_act_q[i]) : 1'b1) ^ pol[i]);
  end

  // State registers; reset wins over a simultaneous write
  always_ff @(posedge clk) begin
    if (rst) begin
      en_out_q <= '0;
      en_pwm_q <= '0;
      presc_q <= '0;
      run_q <= 1'b0;
      pcnt_q <= '0;
      cnt_q <= '0;
      duty_pend_q <= '{default: '0};
      duty_act_q <= '{default: '0};
      out_q <= '0;
      ps_q <= 1'b0;
    end else begin
      en_out_q <= en_out_d;
      en_pwm_q <= en_pwm_d;
      presc_q <= presc_d;
      run_q <= run_d;
      pcnt_q <= pcnt_d;
      cnt_q <= cnt_d;
      duty_pend_q <= duty_pend_d;
      duty_act_q <= duty_act_d;
      out_q <= out_d;
      ps_q <= wrap;
    end
  end

`ifdef PWM_POLARITY_EN
  logic [NUM_CH-1:0] pol_q, pol_d;
  assign pol = pol_q;

  // Polarity byte writes
  always_comb begin
    pol_d = pol_q;
    for (int k = 0; k < NB; k++)
      if (wr_en && wr_addr == 8'(12 + k)) pol_d[8*k +: 8] = wr_data;
  end

  // Polarity register
  always_ff @(posedge clk) begin
    if (rst) pol_q <= '0;
    else pol_q <= pol_d;
  end
`else
  assign pol = '0;
`endif
endmodule
